uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 78 +++++++
 tb/tb_uart_rx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/bit-rate constants.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_WIDTH   = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value selectable.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// Fixed-rate serial receiver: start, DATA_WIDTH data bits LSB-first, stop; each bit
// is sampled at its midpoint and par_out updates only on a correctly framed word.
module uart_rx import uart_pkg::*; #(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  output logic [DATA_WIDTH-1:0] par_out
);
  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  rx_state_e             state;
  logic                  rx;
  logic [TICK_W-1:0]     tick;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (din),
    .q    (rx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick <= '0;
          if (!rx) state <= START;
        end
        START: begin
          // Half a bit in: a line that has gone back high was only a glitch.
          if (tick == TICK_HALF) begin
            tick    <= '0;
            bit_idx <= '0;
            state   <= rx ? IDLE : DATA;
          end else tick <= tick + 1'b1;
        end
        DATA: begin
          if (tick == TICK_FULL) begin
            tick  <= '0;
            // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
            shreg <= DATA_WIDTH'({rx, shreg} >> 1);
            if (bit_idx == IDX_LAST) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else tick <= tick + 1'b1;
        end
        STOP: begin
          if (tick == TICK_FULL) begin
            tick <= '0;
            if (rx) begin
              par_out <= shreg;
              state   <= IDLE;
            end else state <= WAIT_IDLE;
          end else tick <= tick + 1'b1;
        end
        WAIT_IDLE: begin
          // Hold off through a break so a long low line is not read as a new start.
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios then random frames against a
// last-good-word reference model.
module tb_uart_rx;
  localparam int DW  = 8;
  localparam int CPB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          din;
  logic [DW-1:0] par_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_word;

  uart_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .par_out(par_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_clks(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    din = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame; par_out must hold its old value through the data bits and
  // show the model's value at the end of the stop bit.
  task automatic send_frame(input logic [DW-1:0] data, input logic stop_ok, input string tag);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) begin
      send_bit(data[i]);
      if (i == DW/2) check({tag, "_hold"}, par_out, exp_word);
    end
    send_bit(stop_ok);
    if (stop_ok) exp_word = data;
    check({tag, "_end"}, par_out, exp_word);
  endtask

  initial begin
    logic [DW-1:0] d;
    int kind;

    // Reset with an undriven line
    reset = 1'b0;
    din   = 1'bx;
    exp_word = '0;
    #20;
    check("reset_x", par_out, exp_word);
    @(negedge clk);
    din   = 1'b1;
    reset = 1'b1;
    idle_clks(10 + 3 * CPB);
    check("no_spurious", par_out, exp_word);

    idle_clks(10);
    send_frame(8'h55, 1'b1, "f55");

    // Back-to-back, no idle gap between stop and next start
    send_frame(8'h55, 1'b1, "b2b_55");
    send_frame(8'hA3, 1'b1, "b2b_a3");

    // Short glitch must not start a frame
    idle_clks(CPB);
    din = 1'b0;
    repeat (4) @(negedge clk);
    idle_clks(3 * CPB);
    check("glitch", par_out, exp_word);

    // Framing error then recovery
    send_frame(8'hFF, 1'b0, "bad_stop");
    idle_clks(2 * CPB);
    check("after_break", par_out, exp_word);
    send_frame(8'h0F, 1'b1, "f0f");

    // Reset during data bit 3
    idle_clks(CPB);
    din = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    din = 1'b0;
    repeat (CPB/2) @(negedge clk);
    reset = 1'b0;
    exp_word = '0;
    #1;
    check("reset_mid", par_out, exp_word);
    @(negedge clk);
    din = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_clks(2 * CPB);
    check("reset_idle", par_out, exp_word);
    send_frame(8'h3C, 1'b1, "f3c");

    // Random traffic: good frames, framing errors, glitches, random gaps
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(9);
      d = DW'($urandom);
      if (kind == 0) begin
        send_frame(d, 1'b0, "rnd_bad");
        idle_clks(CPB + $urandom_range(20));
      end else if (kind == 1) begin
        din = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        idle_clks(2 * CPB);
        check("rnd_glitch", par_out, exp_word);
      end else begin
        send_frame(d, 1'b1, "rnd_ok");
        idle_clks($urandom_range(3) == 0 ? 0 : $urandom_range(1, 20));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
